// File: rtl/omsp_dma_copy_pkg.sv
// Shared constants for the openMSP430 DMA block-copy engine:
// register offsets, CTL bit positions and FSM state encodings.
package omsp_dma_copy_pkg;

  localparam logic [1:0] REG_SRC = 2'd0;
  localparam logic [1:0] REG_DST = 2'd1;
  localparam logic [1:0] REG_CNT = 2'd2;
  localparam logic [1:0] REG_CTL = 2'd3;

  localparam int unsigned CTL_START   = 0;
  localparam int unsigned CTL_ABORT   = 1;
  localparam int unsigned CTL_BUSY    = 2;
  localparam int unsigned CTL_DONE    = 3;
  localparam int unsigned CTL_ERR     = 4;
  localparam int unsigned CTL_IE      = 5;
  localparam int unsigned CTL_PRIO    = 6;
  localparam int unsigned CTL_SRC_INC = 7;
  localparam int unsigned CTL_DST_INC = 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_CAP  = 2'd2;
  localparam logic [1:0] S_WR   = 2'd3;

endpackage

// File: rtl/omsp_dma_copy_regs.sv
// CPU-visible register file of the DMA engine: decode, byte writes, W1C status,
// per_dout read mux and the per-word SRC/DST/CNT updates requested by the FSM.
module omsp_dma_regs
  import omsp_dma_copy_pkg::*;
#(
  parameter logic [14:0] BASE_ADDR = 15'h0190
) (
  input  logic        mclk,
  input  logic        puc_rst,
  input  logic [13:0] per_addr,
  input  logic [15:0] per_din,
  input  logic        per_en,
  input  logic [1:0]  per_we,
  output logic [15:0] per_dout,
  input  logic        busy,
  input  logic        word_done,
  input  logic        start_ok,
  input  logic        set_done,
  input  logic        set_err,
  output logic [14:0] src,
  output logic [14:0] dst,
  output logic [15:0] cnt,
  output logic        ie,
  output logic        prio,
  output logic        src_inc,
  output logic        dst_inc,
  output logic        done,
  output logic        err,
  output logic        start,
  output logic        abort
);

  logic sel, rd, wr;
  logic wr_src, wr_dst, wr_cnt, wr_ctl;

  assign sel    = per_en && (per_addr[13:2] == BASE_ADDR[14:3]);
  assign rd     = sel && (per_we == 2'b00);
  assign wr     = sel && (per_we != 2'b00);
  assign wr_src = wr && (per_addr[1:0] == REG_SRC) && !busy;
  assign wr_dst = wr && (per_addr[1:0] == REG_DST) && !busy;
  assign wr_cnt = wr && (per_addr[1:0] == REG_CNT) && !busy;
  assign wr_ctl = wr && (per_addr[1:0] == REG_CTL);

  assign start  = wr_ctl && per_we[0] && per_din[CTL_START];
  assign abort  = wr_ctl && per_we[0] && per_din[CTL_ABORT];

  // SRC/DST hold word addresses; the CPU sees them as byte addresses (bit 0 = 0).
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      src <= '0;
      dst <= '0;
      cnt <= '0;
    end else begin
      if (wr_src) begin
        if (per_we[1]) src[14:7] <= per_din[15:8];
        if (per_we[0]) src[6:0]  <= per_din[7:1];
      end else if (word_done && src_inc) begin
        src <= src + 15'd1;
      end
      if (wr_dst) begin
        if (per_we[1]) dst[14:7] <= per_din[15:8];
        if (per_we[0]) dst[6:0]  <= per_din[7:1];
      end else if (word_done && dst_inc) begin
        dst <= dst + 15'd1;
      end
      if (wr_cnt) begin
        if (per_we[1]) cnt[15:8] <= per_din[15:8];
        if (per_we[0]) cnt[7:0]  <= per_din[7:0];
      end else if (word_done) begin
        cnt <= cnt - 16'd1;
      end
    end
  end

  // A status set from the FSM takes precedence over a same-cycle CPU clear.
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      ie      <= 1'b0;
      prio    <= 1'b0;
      src_inc <= 1'b0;
      dst_inc <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      if (wr_ctl && per_we[0]) begin
        ie      <= per_din[CTL_IE];
        prio    <= per_din[CTL_PRIO];
        src_inc <= per_din[CTL_SRC_INC];
      end
      if (wr_ctl && per_we[1]) dst_inc <= per_din[CTL_DST_INC];
      if (set_done)
        done <= 1'b1;
      else if (start_ok || (wr_ctl && per_we[0] && per_din[CTL_DONE]))
        done <= 1'b0;
      if (set_err)
        err <= 1'b1;
      else if (start_ok || (wr_ctl && per_we[0] && per_din[CTL_ERR]))
        err <= 1'b0;
    end
  end

  always_comb begin
    per_dout = '0;
    if (rd) begin
      case (per_addr[1:0])
        REG_SRC: per_dout = {src, 1'b0};
        REG_DST: per_dout = {dst, 1'b0};
        REG_CNT: per_dout = cnt;
        default: per_dout = {7'b0, dst_inc, src_inc, prio, ie, err, done, busy, 2'b00};
      endcase
    end
  end

endmodule

// File: rtl/omsp_dma_copy.sv
// DMA initiator for the openMSP430 DMA port: word block copy/fill driven by a
// RD -> CAP -> WR handshake FSM, programmed through the peripheral bus.
module omsp_dma_copy
  import omsp_dma_copy_pkg::*;
#(
  parameter logic [14:0] BASE_ADDR = 15'h0190
) (
  input  logic        mclk,
  input  logic        puc_rst,
  input  logic [13:0] per_addr,
  input  logic [15:0] per_din,
  input  logic        per_en,
  input  logic [1:0]  per_we,
  output logic [15:0] per_dout,
  output logic [14:0] dma_addr,
  output logic [15:0] dma_din,
  output logic        dma_en,
  output logic [1:0]  dma_we,
  output logic        dma_priority,
  input  logic [15:0] dma_dout,
  input  logic        dma_ready,
  input  logic        dma_resp,
  output logic        irq_dma
);

  logic [1:0]  state, state_nxt;
  logic [15:0] data;
  logic        abort_pend;
  logic        busy, start, abort, start_ok, set_done, set_err, word_done;
  logic [14:0] src, dst;
  logic [15:0] cnt;
  logic        ie, prio, src_inc, dst_inc, done, err;

  assign busy = (state != S_IDLE);

  omsp_dma_regs #(.BASE_ADDR(BASE_ADDR)) u_regs (
    .mclk      (mclk),
    .puc_rst   (puc_rst),
    .per_addr  (per_addr),
    .per_din   (per_din),
    .per_en    (per_en),
    .per_we    (per_we),
    .per_dout  (per_dout),
    .busy      (busy),
    .word_done (word_done),
    .start_ok  (start_ok),
    .set_done  (set_done),
    .set_err   (set_err),
    .src       (src),
    .dst       (dst),
    .cnt       (cnt),
    .ie        (ie),
    .prio      (prio),
    .src_inc   (src_inc),
    .dst_inc   (dst_inc),
    .done      (done),
    .err       (err),
    .start     (start),
    .abort     (abort)
  );

  assign irq_dma      = done && ie;
  assign dma_priority = prio;

  always_comb begin
    state_nxt = state;
    start_ok  = 1'b0;
    set_done  = 1'b0;
    set_err   = 1'b0;
    word_done = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (cnt != 16'd0) begin
            start_ok  = 1'b1;
            state_nxt = S_RD;
          end else begin
            set_done = 1'b1;
          end
        end
      end
      S_RD: begin
        if (dma_ready) begin
          if (dma_resp) begin
            set_err   = 1'b1;
            set_done  = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            state_nxt = S_CAP;
          end
        end
      end
      S_CAP: state_nxt = S_WR;
      default: begin
        if (dma_ready) begin
          if (dma_resp) begin
            set_err   = 1'b1;
            set_done  = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            word_done = 1'b1;
            // An abort arriving in the completing cycle still stops after this word.
            if ((cnt == 16'd1) || abort_pend || abort) begin
              set_done  = 1'b1;
              state_nxt = S_IDLE;
            end else begin
              state_nxt = S_RD;
            end
          end
        end
      end
    endcase
  end

  always_comb begin
    dma_en   = 1'b0;
    dma_we   = 2'b00;
    dma_addr = '0;
    dma_din  = '0;
    case (state)
      S_RD: begin
        dma_en   = 1'b1;
        dma_addr = src;
      end
      S_WR: begin
        dma_en   = 1'b1;
        dma_we   = 2'b11;
        dma_addr = dst;
        dma_din  = data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      state      <= S_IDLE;
      data       <= '0;
      abort_pend <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_CAP) data <= dma_dout;
      if (!busy)
        abort_pend <= 1'b0;
      else if (abort)
        abort_pend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_omsp_dma_copy.sv
// Directed bench for omsp_dma_copy with a behavioural memory on the DMA port
// (programmable read/write wait states and error injection).
module tb_omsp_dma_copy;

  localparam logic [13:0] A_SRC = 14'h00C8;
  localparam logic [13:0] A_DST = 14'h00C9;
  localparam logic [13:0] A_CNT = 14'h00CA;
  localparam logic [13:0] A_CTL = 14'h00CB;

  logic        mclk = 1'b0;
  logic        puc_rst = 1'b1;
  logic [13:0] per_addr = '0;
  logic [15:0] per_din = '0;
  logic        per_en = 1'b0;
  logic [1:0]  per_we = 2'b00;
  logic [15:0] per_dout;
  logic [14:0] dma_addr;
  logic [15:0] dma_din;
  logic        dma_en;
  logic [1:0]  dma_we;
  logic        dma_priority;
  logic [15:0] dma_dout;
  logic        dma_ready;
  logic        dma_resp;
  logic        irq_dma;

  int checks = 0;
  int failures = 0;

  omsp_dma_copy #(.BASE_ADDR(15'h0190)) dut (
    .mclk(mclk), .puc_rst(puc_rst), .per_addr(per_addr), .per_din(per_din),
    .per_en(per_en), .per_we(per_we), .per_dout(per_dout), .dma_addr(dma_addr),
    .dma_din(dma_din), .dma_en(dma_en), .dma_we(dma_we), .dma_priority(dma_priority),
    .dma_dout(dma_dout), .dma_ready(dma_ready), .dma_resp(dma_resp), .irq_dma(irq_dma)
  );

  always #5 mclk = ~mclk;

  // Memory: ready after rd_wait/wr_wait extra cycles, read data the cycle after ready.
  logic [15:0] ram [0:1023];
  int unsigned wcnt = 0, rd_wait = 1, wr_wait = 0, reads_done = 0, writes_done = 0, err_at = 0;
  bit          err_en = 1'b0;

  assign dma_ready = dma_en && (wcnt == ((dma_we == 2'b00) ? rd_wait : wr_wait));
  assign dma_resp  = dma_ready && (dma_we == 2'b00) && err_en && (reads_done == err_at);

  always @(posedge mclk) begin
    if (!dma_en || dma_ready) wcnt <= 0; else wcnt <= wcnt + 1;
    if (dma_en && dma_ready && dma_we == 2'b00) begin
      dma_dout   <= ram[dma_addr[9:0]];
      reads_done <= reads_done + 1;
    end
    if (dma_en && dma_ready && dma_we == 2'b11) begin
      ram[dma_addr[9:0]] = dma_din;
      writes_done <= writes_done + 1;
    end
  end

  // Bus monitor: request cycles and request stability while waiting for ready.
  int unsigned en_cycles = 0, stab_err = 0;
  bit          prev_wait = 1'b0;
  logic [14:0] prev_addr;
  logic [1:0]  prev_we;
  always @(negedge mclk) begin
    if (puc_rst) prev_wait = 1'b0;
    else begin
      if (dma_en) en_cycles++;
      if (prev_wait && (!dma_en || dma_addr !== prev_addr || dma_we !== prev_we)) stab_err++;
      prev_wait = dma_en && !dma_ready;
      prev_addr = dma_addr;
      prev_we   = dma_we;
    end
  end

  logic [15:0] v;
  bit          ok;
  int          cyc;
  int unsigned base0, base1;
  logic [15:0] pat [4] = '{16'h1234, 16'hBEEF, 16'h0F0F, 16'h8001};

  task automatic bus_wr(input logic [13:0] a, input logic [15:0] d);
    per_addr = a; per_din = d; per_we = 2'b11; per_en = 1'b1;
    @(posedge mclk); @(negedge mclk);
    per_en = 1'b0; per_we = 2'b00; per_din = '0;
  endtask

  task automatic bus_rd(input logic [13:0] a, output logic [15:0] d);
    per_addr = a; per_we = 2'b00; per_en = 1'b1;
    #1 d = per_dout;
    per_en = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output int cycles, output bit done_ok);
    logic [15:0] c;
    cycles = 0; done_ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      bus_rd(A_CTL, c);
      if (!c[2]) begin done_ok = 1'b1; break; end
      cycles++;
      @(negedge mclk);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge mclk);
    puc_rst = 1'b0;
    @(negedge mclk);
    bus_rd(A_CTL, v); checks++; if (v !== 16'h0000) begin failures++; $display("FAIL rst_ctl got=%h exp=0000", v); end
    bus_rd(A_SRC, v); checks++; if (v !== 16'h0000) begin failures++; $display("FAIL rst_src got=%h exp=0000", v); end
    bus_rd(A_CNT, v); checks++; if (v !== 16'h0000) begin failures++; $display("FAIL rst_cnt got=%h exp=0000", v); end
    checks++; if ({dma_en, dma_we, dma_addr, dma_din, dma_priority, irq_dma} !== '0) begin
      failures++; $display("FAIL rst_outputs got en=%b we=%b addr=%h din=%h prio=%b irq=%b exp all 0",
                           dma_en, dma_we, dma_addr, dma_din, dma_priority, irq_dma); end
    checks++; if (per_dout !== 16'h0000) begin failures++; $display("FAIL rst_per_dout_idle got=%h exp=0000", per_dout); end
  endtask

  task automatic test_copy();
    for (int i = 0; i < 4; i++) begin ram[10'h100 + i] = pat[i]; ram[10'h180 + i] = '0; end
    ram[10'h184] = 16'hFFFF;
    rd_wait = 1; wr_wait = 0;
    bus_wr(A_SRC, 16'h0200); bus_wr(A_DST, 16'h0300); bus_wr(A_CNT, 16'h0004);
    bus_wr(A_CTL, 16'h01A1);
    wait_idle(100, cyc, ok);
    checks++; if (!ok) begin failures++; $display("FAIL copy_timeout got busy exp idle"); end
    checks++; if (cyc !== 16) begin failures++; $display("FAIL copy_busy_cycles got=%0d exp=16", cyc); end
    bus_rd(A_CTL, v); checks++; if (v !== 16'h01A8) begin failures++; $display("FAIL copy_ctl got=%h exp=01a8", v); end
    checks++; if (irq_dma !== 1'b1) begin failures++; $display("FAIL copy_irq got=%b exp=1", irq_dma); end
    bus_rd(A_CNT, v); checks++; if (v !== 16'h0000) begin failures++; $display("FAIL copy_cnt got=%h exp=0000", v); end
    bus_rd(A_SRC, v); checks++; if (v !== 16'h0208) begin failures++; $display("FAIL copy_src got=%h exp=0208", v); end
    bus_rd(A_DST, v); checks++; if (v !== 16'h0308) begin failures++; $display("FAIL copy_dst got=%h exp=0308", v); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (ram[10'h180 + i] !== pat[i]) begin failures++; $display("FAIL copy_data[%0d] got=%h exp=%h", i, ram[10'h180 + i], pat[i]); end
    end
    checks++; if (ram[10'h184] !== 16'hFFFF) begin failures++; $display("FAIL copy_overrun got=%h exp=ffff", ram[10'h184]); end
    bus_rd(14'h00CC, v); checks++; if (v !== 16'h0000) begin failures++; $display("FAIL copy_unmapped_read got=%h exp=0000", v); end
  endtask

  task automatic test_fill_wrap();
    ram[10'h200] = 16'hA5A5;
    ram[10'h3FE] = '0; ram[10'h3FF] = '0; ram[10'h000] = '0; ram[10'h001] = 16'h1111;
    bus_wr(A_SRC, 16'h0400); bus_wr(A_DST, 16'hFFFC); bus_wr(A_CNT, 16'h0003);
    bus_wr(A_CTL, 16'h0101);
    wait_idle(100, cyc, ok);
    checks++; if (!ok) begin failures++; $display("FAIL fill_timeout got busy exp idle"); end
    checks++; if ({ram[10'h3FE], ram[10'h3FF], ram[10'h000]} !== {3{16'hA5A5}}) begin failures++;
      $display("FAIL fill_data got=%h %h %h exp=a5a5 x3", ram[10'h3FE], ram[10'h3FF], ram[10'h000]); end
    checks++; if (ram[10'h001] !== 16'h1111) begin failures++; $display("FAIL fill_overrun got=%h exp=1111", ram[10'h001]); end
    bus_rd(A_SRC, v); checks++; if (v !== 16'h0400) begin failures++; $display("FAIL fill_src got=%h exp=0400", v); end
    bus_rd(A_DST, v); checks++; if (v !== 16'h0002) begin failures++; $display("FAIL fill_dst_wrap got=%h exp=0002", v); end
  endtask

  task automatic test_wait_states();
    ram[10'h300] = 16'h5A01; ram[10'h301] = 16'h5A02; ram[10'h380] = '0; ram[10'h381] = '0;
    rd_wait = 3; wr_wait = 3;
    bus_wr(A_SRC, 16'h0600); bus_wr(A_DST, 16'h0700); bus_wr(A_CNT, 16'h0002);
    base0 = en_cycles; base1 = stab_err;
    bus_wr(A_CTL, 16'h0181);
    wait_idle(200, cyc, ok);
    checks++; if (!ok) begin failures++; $display("FAIL wait_timeout got busy exp idle"); end
    checks++; if (cyc !== 18) begin failures++; $display("FAIL wait_busy_cycles got=%0d exp=18", cyc); end
    checks++; if (en_cycles - base0 !== 16) begin failures++; $display("FAIL wait_en_cycles got=%0d exp=16", en_cycles - base0); end
    checks++; if (stab_err - base1 !== 0) begin failures++; $display("FAIL wait_req_stable got=%0d changes exp=0", stab_err - base1); end
    checks++; if ({ram[10'h380], ram[10'h381]} !== {16'h5A01, 16'h5A02}) begin failures++;
      $display("FAIL wait_data got=%h %h exp=5a01 5a02", ram[10'h380], ram[10'h381]); end
  endtask

  task automatic test_bus_error();
    for (int i = 0; i < 4; i++) begin ram[10'h400 + i] = 16'h6600 + 16'(i); ram[10'h500 + i] = '0; end
    rd_wait = 1; wr_wait = 0;
    bus_wr(A_SRC, 16'h0800); bus_wr(A_DST, 16'h0A00); bus_wr(A_CNT, 16'h0004);
    err_at = reads_done + 1; err_en = 1'b1; base0 = writes_done;
    bus_wr(A_CTL, 16'h01A1);
    wait_idle(100, cyc, ok);
    err_en = 1'b0;
    checks++; if (!ok) begin failures++; $display("FAIL err_timeout got busy exp idle"); end
    bus_rd(A_CTL, v); checks++; if (v !== 16'h01B8) begin failures++; $display("FAIL err_ctl got=%h exp=01b8", v); end
    bus_rd(A_CNT, v); checks++; if (v !== 16'h0003) begin failures++; $display("FAIL err_cnt got=%h exp=0003", v); end
    bus_rd(A_SRC, v); checks++; if (v !== 16'h0802) begin failures++; $display("FAIL err_src got=%h exp=0802", v); end
    checks++; if (writes_done - base0 !== 1) begin failures++; $display("FAIL err_writes got=%0d exp=1", writes_done - base0); end
    checks++; if ({ram[10'h500], ram[10'h501]} !== {16'h6600, 16'h0000}) begin failures++;
      $display("FAIL err_data got=%h %h exp=6600 0000", ram[10'h500], ram[10'h501]); end
  endtask

  task automatic test_abort();
    for (int i = 0; i < 8; i++) begin ram[10'h600 + i] = 16'h7700 + 16'(i); ram[10'h700 + i] = '0; end
    rd_wait = 3; wr_wait = 0;
    bus_wr(A_SRC, 16'h0C00); bus_wr(A_DST, 16'h0E00); bus_wr(A_CNT, 16'h0008);
    base0 = writes_done;
    bus_wr(A_CTL, 16'h0181);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (dma_en && dma_we == 2'b00 && dma_addr == 15'h0601) begin ok = 1'b1; break; end
      @(negedge mclk);
    end
    checks++; if (!ok) begin failures++; $display("FAIL abort_second_read got none exp addr 0601"); end
    bus_wr(A_CTL, 16'h0182);
    wait_idle(200, cyc, ok);
    checks++; if (!ok) begin failures++; $display("FAIL abort_timeout got busy exp idle"); end
    bus_rd(A_CNT, v); checks++; if (v !== 16'h0006) begin failures++; $display("FAIL abort_cnt got=%h exp=0006", v); end
    bus_rd(A_CTL, v); checks++; if (v !== 16'h0188) begin failures++; $display("FAIL abort_ctl got=%h exp=0188", v); end
    bus_rd(A_SRC, v); checks++; if (v !== 16'h0C04) begin failures++; $display("FAIL abort_src got=%h exp=0c04", v); end
    checks++; if (writes_done - base0 !== 2) begin failures++; $display("FAIL abort_writes got=%0d exp=2", writes_done - base0); end
    checks++; if ({ram[10'h700], ram[10'h701], ram[10'h702]} !== {16'h7700, 16'h7701, 16'h0000}) begin failures++;
      $display("FAIL abort_data got=%h %h %h exp=7700 7701 0000", ram[10'h700], ram[10'h701], ram[10'h702]); end
  endtask

  task automatic test_zero_count_and_reset();
    bus_wr(A_CNT, 16'h0000);
    base0 = en_cycles;
    bus_wr(A_CTL, 16'h0021);
    bus_rd(A_CTL, v); checks++; if (v !== 16'h0028) begin failures++; $display("FAIL zero_ctl got=%h exp=0028", v); end
    checks++; if (irq_dma !== 1'b1) begin failures++; $display("FAIL zero_irq got=%b exp=1", irq_dma); end
    repeat (4) @(negedge mclk);
    checks++; if (en_cycles - base0 !== 0) begin failures++; $display("FAIL zero_no_access got=%0d exp=0", en_cycles - base0); end
    bus_wr(A_CTL, 16'h0028);
    bus_rd(A_CTL, v); checks++; if (v !== 16'h0020) begin failures++; $display("FAIL w1c_ctl got=%h exp=0020", v); end
    checks++; if (irq_dma !== 1'b0) begin failures++; $display("FAIL w1c_irq got=%b exp=0", irq_dma); end
    rd_wait = 3; wr_wait = 0;
    bus_wr(A_SRC, 16'h0200); bus_wr(A_DST, 16'h0300); bus_wr(A_CNT, 16'h0004);
    bus_wr(A_CTL, 16'h01E1);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (dma_en && dma_we == 2'b11) begin ok = 1'b1; break; end
      @(negedge mclk);
    end
    checks++; if (!ok) begin failures++; $display("FAIL rst_mid_write got none exp write"); end
    checks++; if (dma_priority !== 1'b1) begin failures++; $display("FAIL prio_follow got=%b exp=1", dma_priority); end
    puc_rst = 1'b1; per_addr = A_CTL; per_we = 2'b00; per_en = 1'b1;
    #1;
    checks++; if ({dma_en, dma_we, dma_addr, dma_din, dma_priority, irq_dma, per_dout} !== '0) begin failures++;
      $display("FAIL rst_mid_outputs got en=%b we=%b addr=%h din=%h prio=%b irq=%b dout=%h exp all 0",
               dma_en, dma_we, dma_addr, dma_din, dma_priority, irq_dma, per_dout); end
    per_en = 1'b0;
    @(negedge mclk); puc_rst = 1'b0; @(negedge mclk);
    bus_rd(A_CNT, v); checks++; if (v !== 16'h0000) begin failures++; $display("FAIL rst_mid_cnt got=%h exp=0000", v); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = '0;
    test_reset();
    test_copy();
    test_fill_wrap();
    test_wait_states();
    test_bus_error();
    test_abort();
    test_zero_count_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no finish exp finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
